// File: rtl/toy_fetch_mem_bridge.sv
// Instruction-fetch responder: accepts tagged fetch requests, reads a 1-cycle-latency ITCM SRAM
// and returns in-order acks. Define TOY_FETCH_RANGE_CHK_EN to enable the ITCM address range check.
module toy_fetch_mem_bridge #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter int                    ID_WIDTH   = 6,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] ITCM_BASE  = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] ITCM_SIZE  = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_mem_req_vld,
    output logic                  fetch_mem_req_rdy,
    input  logic [ADDR_WIDTH-1:0] fetch_mem_req_addr,
    input  logic [ID_WIDTH-1:0]   fetch_mem_req_entry_id,
    output logic                  fetch_mem_ack_vld,
    input  logic                  fetch_mem_ack_rdy,
    output logic [DATA_WIDTH-1:0] fetch_mem_ack_data,
    output logic [ID_WIDTH-1:0]   fetch_mem_ack_entry_id,
    output logic                  fetch_mem_ack_err,
    output logic                  inst_mem_en,
    output logic [ADDR_WIDTH-1:0] inst_mem_addr,
    input  logic [DATA_WIDTH-1:0] inst_mem_rd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~(ADDR_WIDTH'(DATA_WIDTH / 8) - ADDR_WIDTH'(1));

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } fifo_entry_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("toy_fetch_mem_bridge: DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH < 32 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
        $error("toy_fetch_mem_bridge: DATA_WIDTH must be a power of two >= 32");
    end
    if (ITCM_SIZE == '0 || (ITCM_BASE & ~ALIGN_MASK) != '0) begin : g_bad_itcm
        $error("toy_fetch_mem_bridge: ITCM window must be non-empty and line-aligned");
    end

    logic                  rdy_q;
    logic [CNT_W-1:0]      occ_q;
    logic                  req_hs;
    logic                  ack_hs;
    logic                  mem_rd;
    logic                  s1_vld_q;
    logic [ID_WIDTH-1:0]   s1_id_q;
    logic [DATA_WIDTH-1:0] push_data;
    fifo_entry_t           fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;
    logic                  fifo_empty;

    // rdy_q keeps the request port closed during reset and opens it on the first edge after release.
    assign fetch_mem_req_rdy = rdy_q && (occ_q < DEPTH_C);
    assign req_hs            = fetch_mem_req_vld && fetch_mem_req_rdy;
    assign ack_hs            = fetch_mem_ack_vld && fetch_mem_ack_rdy;

`ifdef TOY_FETCH_RANGE_CHK_EN
    logic req_in_range;
    logic s1_err_q;
    logic err_mem [DEPTH];

    assign req_in_range = (fetch_mem_req_addr >= ITCM_BASE) &&
                          ((fetch_mem_req_addr - ITCM_BASE) < ITCM_SIZE);
    assign mem_rd       = req_hs && req_in_range;
    assign push_data    = s1_err_q ? '0 : inst_mem_rd_data;
`else
    assign mem_rd    = req_hs;
    assign push_data = inst_mem_rd_data;
`endif

    assign inst_mem_en   = mem_rd;
    assign inst_mem_addr = mem_rd ? (fetch_mem_req_addr & ALIGN_MASK) : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            occ_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            case ({req_hs, ack_hs})
                2'b10:   occ_q <= occ_q + CNT_ONE;
                2'b01:   occ_q <= occ_q - CNT_ONE;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Stage 1 tracks the request whose SRAM data appears on inst_mem_rd_data next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_id_q  <= '0;
        end else begin
            s1_vld_q <= req_hs;
            s1_id_q  <= req_hs ? fetch_mem_req_entry_id : '0;
        end
    end

`ifdef TOY_FETCH_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err_q <= 1'b0;
        end else begin
            s1_err_q <= req_hs && !req_in_range;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (s1_vld_q) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (ack_hs) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({s1_vld_q, ack_hs})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; fifo_cnt_q decides validity and the outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (s1_vld_q) begin
            fifo_mem[wr_ptr_q] <= '{data: push_data, id: s1_id_q};
`ifdef TOY_FETCH_RANGE_CHK_EN
            err_mem[wr_ptr_q]  <= s1_err_q;
`endif
        end
    end

    assign fifo_empty = (fifo_cnt_q == '0);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        fetch_mem_ack_vld      = 1'b0;
        fetch_mem_ack_data     = '0;
        fetch_mem_ack_entry_id = '0;
        fetch_mem_ack_err      = 1'b0;
        if (!fifo_empty) begin
            fetch_mem_ack_vld      = 1'b1;
            fetch_mem_ack_data     = fifo_mem[rd_ptr_q].data;
            fetch_mem_ack_entry_id = fifo_mem[rd_ptr_q].id;
`ifdef TOY_FETCH_RANGE_CHK_EN
            fetch_mem_ack_err      = err_mem[rd_ptr_q];
`endif
        end
    end

endmodule

// File: tb/tb_toy_fetch_mem_bridge.sv
// Self-checking bench for toy_fetch_mem_bridge: directed steps plus a scoreboard of expected acks,
// with an SRAM model that returns an address-derived line one cycle after enable.
module tb_toy_fetch_mem_bridge;

    localparam int AW    = 32;
    localparam int DW    = 128;
    localparam int IW    = 6;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_vld;
    logic          req_rdy;
    logic [AW-1:0] req_addr;
    logic [IW-1:0] req_id;
    logic          ack_vld;
    logic          ack_rdy;
    logic [DW-1:0] ack_data;
    logic [IW-1:0] ack_id;
    logic          ack_err;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   ack_cyc_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   req_cnt  = 0;
    int   ack_cnt  = 0;
    int   dropped  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    toy_fetch_mem_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .fetch_mem_req_vld     (req_vld),
        .fetch_mem_req_rdy     (req_rdy),
        .fetch_mem_req_addr    (req_addr),
        .fetch_mem_req_entry_id(req_id),
        .fetch_mem_ack_vld     (ack_vld),
        .fetch_mem_ack_rdy     (ack_rdy),
        .fetch_mem_ack_data    (ack_data),
        .fetch_mem_ack_entry_id(ack_id),
        .fetch_mem_ack_err     (ack_err),
        .inst_mem_en           (mem_en),
        .inst_mem_addr         (mem_addr),
        .inst_mem_rd_data      (mem_rd_data)
    );

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5678, {a[15:0], a[31:16]}};
    endfunction

    function automatic logic in_itcm(input logic [AW-1:0] a);
`ifdef TOY_FETCH_RANGE_CHK_EN
        return a < 32'h0001_0000;
`else
        return (a == a);
`endif
    endfunction

    // SRAM model: 1-cycle read latency; garbage when not enabled so stale captures show up.
    always @(posedge clk) begin
        if (mem_en) mem_rd_data <= line_of(mem_addr);
        else        mem_rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: SRAM pins every cycle, scoreboard push on request handshake, pop/compare on ack.
    logic          mon_hs;
    logic          mon_en;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_id;
    exp_t          mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            mon_hs = req_vld && req_rdy;
            mon_en = mon_hs && in_itcm(req_addr);
            check("inst_mem_en", DW'(mem_en), DW'(mon_en));
            check("inst_mem_addr", DW'(mem_addr), DW'(mon_en ? (req_addr & ~32'hF) : 32'h0));
            if (mon_hs) begin
                mon_exp.id   = req_id;
                mon_exp.err  = !in_itcm(req_addr);
                mon_exp.data = mon_exp.err ? '0 : line_of(req_addr & ~32'hF);
                sb_q.push_back(mon_exp);
                req_cnt++;
            end
            if (prev_stall) begin
                check("stall_vld_held", DW'(ack_vld), DW'(1));
                check("stall_id_stable", DW'(ack_id), DW'(prev_id));
                check("stall_data_stable", ack_data, prev_data);
            end
            if (ack_vld && ack_rdy) begin
                ack_cnt++;
                ack_cyc_q.push_back(cyc);
                check("ack_has_expectation", DW'(sb_q.size() != 0), DW'(1));
                if (sb_q.size() != 0) begin
                    mon_exp = sb_q.pop_front();
                    check("ack_entry_id", DW'(ack_id), DW'(mon_exp.id));
                    check("ack_data", ack_data, mon_exp.data);
                    check("ack_err", DW'(ack_err), DW'(mon_exp.err));
                end
            end
            prev_stall = ack_vld && !ack_rdy;
            prev_data  = ack_data;
            prev_id    = ack_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ack_rdy = 1'b1;
        for (int i = 0; i < 200 && (sb_q.size() != 0 || ack_vld); i++) tick();
        check("drain_sb_empty", DW'(sb_q.size()), DW'(0));
    endtask

    // Hold req_vld with ack_rdy low: exactly DEPTH handshakes, then release and watch rdy recover.
    task automatic fill_and_release(input logic [AW-1:0] base);
        int  hs;
        logic got;
        hs      = 0;
        ack_rdy = 1'b0;
        req_vld = 1'b1;
        req_addr = base;
        req_id   = '0;
        repeat (8) begin
            @(negedge clk);
            got = req_rdy;
            tick();
            if (got) begin
                hs++;
                req_addr = base + AW'(hs * 16);
                req_id   = IW'(hs);
            end
        end
        check("fill_handshakes", DW'(hs), DW'(DEPTH));
        @(negedge clk);
        check("fill_rdy_low", DW'(req_rdy), DW'(0));
        check("fill_en_low", DW'(mem_en), DW'(0));
        tick();
        req_vld = 1'b0;
        ack_rdy = 1'b1;
        @(negedge clk);
        check("rdy_low_during_first_pop", DW'(req_rdy), DW'(0));
        tick();
        @(negedge clk);
        check("rdy_back_after_first_pop", DW'(req_rdy), DW'(1));
        drain();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        logic acc;

        req_vld  = 1'b0;
        req_addr = '0;
        req_id   = '0;
        ack_rdy  = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #11;

        // Reset values
        check("rst_req_rdy", DW'(req_rdy), DW'(0));
        check("rst_ack_vld", DW'(ack_vld), DW'(0));
        check("rst_ack_data", ack_data, '0);
        check("rst_ack_id", DW'(ack_id), DW'(0));
        check("rst_ack_err", DW'(ack_err), DW'(0));
        check("rst_mem_en", DW'(mem_en), DW'(0));
        check("rst_mem_addr", DW'(mem_addr), DW'(0));
        rst_n = 1'b1;
        tick();
        check("rdy_after_release", DW'(req_rdy), DW'(1));

        // Single request, latency N -> ack in N+2
        ack_rdy  = 1'b1;
        req_vld  = 1'b1;
        req_addr = 32'h0000_0014;
        req_id   = 6'd5;
        @(negedge clk);
        check("single_mem_en", DW'(mem_en), DW'(1));
        check("single_mem_addr", DW'(mem_addr), DW'(32'h0000_0010));
        tick();
        req_vld = 1'b0;
        @(negedge clk);
        check("single_no_ack_n1", DW'(ack_vld), DW'(0));
        tick();
        @(negedge clk);
        check("single_ack_n2", DW'(ack_vld), DW'(1));
        check("single_ack_id", DW'(ack_id), DW'(5));
        check("single_ack_data", ack_data, line_of(32'h0000_0010));
        tick();
        drain();

        // Back-to-back stream of 8
        ack_cyc_q.delete();
        for (int i = 0; i < 8; i++) begin
            req_vld  = 1'b1;
            req_addr = AW'(i * 16);
            req_id   = IW'(i);
            @(negedge clk);
            check("stream_rdy", DW'(req_rdy), DW'(1));
            tick();
        end
        req_vld = 1'b0;
        drain();
        check("stream_ack_count", DW'(ack_cyc_q.size()), DW'(8));
        if (ack_cyc_q.size() >= 8)
            check("stream_ack_consecutive", DW'(ack_cyc_q[7] - ack_cyc_q[0]), DW'(7));

        // Backpressure fill
        fill_and_release(32'h0000_0200);

        // Random traffic, 1000 requests
        sent = 0;
        ack_rdy = 1'b0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            if (!req_vld && $urandom_range(1, 0) == 1) begin
                req_vld  = 1'b1;
                req_addr = ($urandom & 32'h0000_FFF0) | AW'($urandom_range(15, 0));
                req_id   = IW'(sent);
            end
            ack_rdy = ($urandom_range(1, 0) == 1);
            @(negedge clk);
            acc = req_vld && req_rdy;
            tick();
            if (acc) begin
                sent++;
                req_vld = 1'b0;
            end
        end
        check("rand_sent", DW'(sent), DW'(1000));
        req_vld = 1'b0;
        drain();

        // Asynchronous reset with 3 outstanding
        ack_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_vld  = 1'b1;
            req_addr = 32'h0000_0300 + AW'(i * 16);
            req_id   = IW'(40 + i);
            tick();
        end
        req_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ack_vld", DW'(ack_vld), DW'(0));
        check("async_rst_req_rdy", DW'(req_rdy), DW'(0));
        dropped += sb_q.size();
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        ack_rdy = 1'b1;
        tick();
        check("post_rst_rdy", DW'(req_rdy), DW'(1));
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_stale_ack", DW'(ack_vld), DW'(0));
        end
        tick();
        fill_and_release(32'h0000_0400);

`ifdef TOY_FETCH_RANGE_CHK_EN
        // Out-of-range request followed by an in-range one
        ack_rdy  = 1'b1;
        req_vld  = 1'b1;
        req_addr = 32'h0002_0000;
        req_id   = 6'd9;
        @(negedge clk);
        check("oor_no_sram_en", DW'(mem_en), DW'(0));
        tick();
        req_addr = 32'h0000_0020;
        req_id   = 6'd10;
        @(negedge clk);
        check("inrange_sram_en", DW'(mem_en), DW'(1));
        tick();
        req_vld = 1'b0;
        drain();
`endif

        check("no_loss_no_dup", DW'(ack_cnt), DW'(req_cnt - dropped));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/toy_fetch_mem_bridge.md
Name: toy_fetch_mem_bridge

Overview:
Instruction-fetch memory responder between the core's fetch request/ack port and a single-port ITCM SRAM with fixed 1-cycle read latency. It accepts tagged fetch requests (addr + ROB entry id) on a valid/ready handshake and issues SRAM reads. Read data is captured into a response FIFO, and acks are returned in request order on a valid/ready handshake carrying data and the original entry id. It occupies the slot of the instruction-memory model inside toy_scalar, driving the inst_mem_* SRAM pins.

Parameters:
ADDR_WIDTH, 32, request/SRAM address width
DATA_WIDTH, 128, fetch data width (FETCH_DATA_WIDTH); power of two, >= 32
ID_WIDTH, 6, entry id width (ROB_ENTRY_ID_WIDTH)
DEPTH, 4, max outstanding requests (in-flight + buffered); >= 2, power of two
ITCM_BASE, 32'h0000_0000, ITCM base address (used only with the optional feature)
ITCM_SIZE, 32'h0001_0000, ITCM size in bytes (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
fetch_mem_req_vld  in  1  request valid
fetch_mem_req_rdy  out  1  request ready
fetch_mem_req_addr  in  ADDR_WIDTH  byte address
fetch_mem_req_entry_id  in  ID_WIDTH  tag echoed on ack
fetch_mem_ack_vld  out  1  response valid
fetch_mem_ack_rdy  in  1  response ready
fetch_mem_ack_data  out  DATA_WIDTH  fetched line
fetch_mem_ack_entry_id  out  ID_WIDTH  tag of the request
fetch_mem_ack_err  out  1  access error (optional feature; otherwise tied 0)
inst_mem_en  out  1  SRAM enable
inst_mem_addr  out  ADDR_WIDTH  SRAM address, line-aligned
inst_mem_rd_data  in  DATA_WIDTH  SRAM read data, valid 1 cycle after en

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - fetch_mem_req_rdy=0 while rst_n=0, and 1 from the first cycle after release.
  - ack_vld=0, ack_data=0, ack_entry_id=0, ack_err=0.
  - inst_mem_en=0, inst_mem_addr=0.
- Occupancy counter occ (0..DEPTH) counts requests that are accepted but not yet acked:
  - +1 on request handshake (req_vld && req_rdy).
  - -1 on ack handshake (ack_vld && ack_rdy).
  - Both in the same cycle leaves occ unchanged.
- req_rdy = (occ < DEPTH).
  - This is registered-state based, with no same-cycle pop look-ahead.
  - Consequence: when occ==DEPTH and an ack pops, rdy rises only in the next cycle.
- inst_mem_en and inst_mem_addr are combinational from the handshake:
  - inst_mem_en = req_vld && req_rdy.
  - inst_mem_addr = req_addr with the low log2(DATA_WIDTH/8) bits forced to 0.
  - When en=0, addr holds 0.
- Stage-1 register (s1_vld, s1_id) is loaded on handshake and cleared otherwise.
- In the cycle after s1_vld, {inst_mem_rd_data, s1_id} is pushed into the FIFO (DEPTH entries).
  - The FIFO cannot overflow, by the occ bound.
- Ack is driven from the FIFO head:
  - ack_vld = !fifo_empty.
  - data/id are stable while vld && !rdy.
  - Pop on ack handshake.
  - Ordering is strictly in request order.
- Latency: request accepted in cycle N → SRAM read in N → FIFO write at the end of N+1 → ack_vld in N+2 at the earliest.
- Throughput: 1 request/cycle sustained with ack_rdy=1 and DEPTH >= 3. DEPTH=2 gives 2 requests per 3 cycles.
- Pointers: the FIFO rd/wr pointers wrap modulo DEPTH, with a separate count for full/empty.
- Simultaneous push and pop on an empty FIFO: data is not bypassed; ack_vld rises the cycle after the push.
- Reset mid-operation flushes s1, the FIFO and occ. Outstanding requests are dropped with no ack.
- ack_rdy held low: the FIFO fills, occ reaches DEPTH, req_rdy=0, and inst_mem_en=0 from then on.

Optional Feature:
Macro TOY_FETCH_RANGE_CHK_EN.
- Defined:
  - An accepted request whose addr falls outside [ITCM_BASE, ITCM_BASE+ITCM_SIZE) asserts inst_mem_en=0 (the SRAM is not accessed).
  - It still occupies a slot and travels through s1 with an err flag.
  - Its FIFO entry has data=0 and err=1, and it is acked in order with ack_err=1.
  - In-range requests return ack_err=0.
- Undefined: no range check, ack_err tied 0, and every accepted request reads the SRAM.

Test Plan:
- Reset release, single request addr=0x0000_0014, id=5, ack_rdy=1:
  - inst_mem_en=1 with inst_mem_addr=0x0000_0010 in cycle N.
  - ack_vld in N+2 with entry_id=5 and data=SRAM[0x10].
- Back-to-back stream of 8 requests, ids 0..7, addr 0x0,0x10,...,0x70, ack_rdy=1, DEPTH=4:
  - req_rdy stays 1 throughout.
  - 8 acks arrive in consecutive cycles, in id order 0..7.
- ack_rdy=0 with req_vld held 1:
  - Exactly 4 handshakes, then req_rdy=0 and inst_mem_en=0.
  - Raising ack_rdy pops id order 0..3, and req_rdy returns 1 the cycle after the first pop.
- Random ack_rdy (50%) and random req_vld, 1000 requests: a scoreboard checks in-order ids, data against the SRAM model, and no loss or duplication.
- rst_n pulsed low asynchronously with 3 outstanding requests:
  - ack_vld=0 and req_rdy=0 immediately.
  - After release, occ=0, req_rdy=1, and no stale acks appear.
- With TOY_FETCH_RANGE_CHK_EN defined, addr=0x0002_0000 (id=9) followed by addr=0x20 (id=10):
  - No SRAM enable for id 9; its ack has err=1 and data=0.
  - Next, id 10 acks with err=0 and SRAM data.
